// File: rtl/mux4_scan_ctrl.sv
// Channel scanner around a 4:1 mux: steps sel over the enabled channels,
// waits a settle time on each, samples y_in and reports a 4-bit result word.
module mux4_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] chan_mask,
  input  logic       y_in,
  output logic [1:0] sel,
  output logic [3:0] sample,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);

  state_t           state;
  logic [3:0]       mask;
  logic [3:0]       shadow;
  logic [CNT_W-1:0] cnt;

  logic [1:0] first_idx;
  logic [1:0] next_idx;
  logic       has_next;

  // lowest enabled channel of the incoming mask (0 when mask is empty)
  always_comb begin
    first_idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (chan_mask[k]) first_idx = 2'(k);
    end
  end

  // next enabled channel strictly above the current sel
  always_comb begin
    next_idx = sel;
    has_next = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k] && (k > int'(sel))) begin
        next_idx = 2'(k);
        has_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= '0;
      sample <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      mask   <= '0;
      shadow <= '0;
      cnt    <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask   <= chan_mask;
            shadow <= '0;
            busy   <= 1'b1;
            sel    <= first_idx;
            cnt    <= CNT_INIT;
            state  <= (chan_mask != 4'b0) ? SETTLE : DONE;
          end
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shadow[sel] <= y_in;
            if (has_next) begin
              sel <= next_idx;
              cnt <= CNT_INIT;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          sample <= shadow;
          valid  <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl: a settle-2 instance behind a modelled
// 4:1 mux and a settle-0 instance fed by a toggling y_in.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] chan_mask;
  logic       y_in;
  logic [1:0] sel;
  logic [3:0] sample;
  logic       valid;
  logic       busy;
  logic [3:0] mux_in;

  logic       start0;
  logic [3:0] mask0;
  logic       y_in0;
  logic [1:0] sel0;
  logic [3:0] sample0;
  logic       valid0;
  logic       busy0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign y_in = mux_in[sel];

  mux4_scan_ctrl #(.SETTLE_CYCLES(2), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .chan_mask(chan_mask),
    .y_in(y_in), .sel(sel), .sample(sample), .valid(valid), .busy(busy)
  );

  mux4_scan_ctrl #(.SETTLE_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .chan_mask(mask0),
    .y_in(y_in0), .sel(sel0), .sample(sample0), .valid(valid0),
    .busy(busy0)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One scan on the settle-2 instance; checks sel/busy/valid every cycle.
  task automatic scan(input logic [3:0] m, input logic [3:0] exp,
                      input bit pre, input bit disturb, input bit chain,
                      input logic [3:0] nm, input logic [3:0] nmux);
    int n;
    int idx;
    logic [1:0] lst[4];
    n = 0;
    for (int k = 0; k < 4; k++) begin
      lst[k] = 2'd0;
      if (m[k]) begin
        lst[n] = 2'(k);
        n++;
      end
    end
    if (!pre) begin
      @(negedge clk);
      start = 1'b1;
      chan_mask = m;
    end
    @(posedge clk);
    for (int t = 0; t <= 3 * n + 1; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (disturb && t == 4) begin
        start = 1'b1;
        chan_mask = 4'b0001;
      end
      if (t <= 3 * n) begin
        idx = (t / 3 < n) ? t / 3 : n - 1;
        chk("busy_scan", int'(busy), 1);
        chk("valid_low", int'(valid), 0);
        chk("sel_seq", int'(sel), (n == 0) ? 0 : int'(lst[idx]));
      end else begin
        chk("valid_pulse", int'(valid), 1);
        chk("busy_done", int'(busy), 0);
        chk("sample", int'(sample), int'(exp));
        if (chain) begin
          start = 1'b1;
          chan_mask = nm;
          mux_in = nmux;
        end
      end
    end
    if (!chain) begin
      @(negedge clk);
      chk("valid_drop", int'(valid), 0);
      chk("sample_hold", int'(sample), int'(exp));
    end
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    start = 1'b0;
    chan_mask = 4'b0;
    mux_in = 4'b0;
    start0 = 1'b0;
    mask0 = 4'b0;
    y_in0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sel", int'(sel), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // full scan, disturbed mid-way, chained into a back-to-back scan
    mux_in = 4'b1010;
    scan(4'b1111, 4'b1010, 1'b0, 1'b1, 1'b1, 4'b0110, 4'b0100);
    scan(4'b0110, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0, 4'b0);

    // sparse mask
    mux_in = 4'b1111;
    scan(4'b0101, 4'b0101, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);

    // async reset in the middle of channel 2 settle
    @(negedge clk);
    start = 1'b1;
    chan_mask = 4'b1111;
    @(posedge clk);
    repeat (7) @(negedge clk);
    start = 1'b0;
    chk("pre_rst_sel", int'(sel), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_sel", int'(sel), 0);
    chk("arst_sample", int'(sample), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
    chk("no_valid_after_rst", int'(seen), 0);
    mux_in = 4'b0110;
    scan(4'b1111, 4'b0110, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);

    // empty mask
    scan(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0);

    // zero settle with y_in toggling each cycle
    @(negedge clk);
    y_in0 = 1'b0;
    start0 = 1'b1;
    mask0 = 4'b1111;
    @(posedge clk);
    for (int t = 0; t <= 5; t++) begin
      @(negedge clk);
      start0 = 1'b0;
      y_in0 = ~y_in0;
      if (t <= 3) begin
        chk("s0_sel", int'(sel0), t);
        chk("s0_busy", int'(busy0), 1);
      end else if (t == 4) begin
        chk("s0_valid_low", int'(valid0), 0);
        chk("s0_busy_done", int'(busy0), 1);
      end else begin
        chk("s0_valid", int'(valid0), 1);
        chk("s0_sample", int'(sample0), 5);
        chk("s0_busy_low", int'(busy0), 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
